// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: N-way round-robin arbiter in front of the single main-memory
// cache-line port. One transaction is outstanding at a time. The owner may kill
// its request; the memory side is then drained (no ack to the requester) until
// memory acks or a timeout forces the port back to idle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_i/kill_i      per-requester request (held until ack/kill) and abort
//   addr_i/wdata_i    flattened per-requester address / write line
//   wen_i             per-requester write enable
//   ack_o, rdata_o    one-cycle completion to the owner, read line with it
//   mem_*_o           registered request to memory, stable while mem_req_o
//   mem_ack_i/rdata_i memory completion and read line
//   busy_o            arbiter not idle
//   timeout_o         one-cycle pulse when a kill drain ends by timeout

// Per-requester slice: eligibility for arbitration and ack steering.
module mem_rr_arbiter_lane (
  input  logic req,
  input  logic kill,
  input  logic sel,
  input  logic fire,
  output logic elig,
  output logic ack
);
  assign elig = req & ~kill;
  assign ack  = sel & fire;
endmodule

module mem_rr_arbiter #(
  parameter int N_REQ       = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 240
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         kill_i,
  input  logic [N_REQ*ADDR_W-1:0]  addr_i,
  input  logic [N_REQ*DATA_W-1:0]  wdata_i,
  input  logic [N_REQ-1:0]         wen_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic                     mem_wen_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_KILL} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic [N_REQ-1:0]              elig;
  logic [N_REQ-1:0][ADDR_W-1:0]  addr_arr;
  logic [N_REQ-1:0][DATA_W-1:0]  wdata_arr;
  logic                          win_vld;
  logic [OW-1:0]                 win_idx;
  logic [OW-1:0]                 cand;
  logic                          ack_fire;
  logic                          timer_hit;

  assign addr_arr  = addr_i;
  assign wdata_arr = wdata_i;

  // Completion towards the owner; reset suppresses any ack in flight.
  assign ack_fire  = ~rst & (state_q == S_BUSY) & mem_ack_i & ~kill_i[owner_q];
  assign timer_hit = (timer_q == TW'(TIMEOUT_CYC - 1));
  // A memory ack in the last drain cycle beats the timeout.
  assign timeout_o = ~rst & (state_q == S_KILL) & ~mem_ack_i & timer_hit;
  assign rdata_o   = ack_fire ? mem_rdata_i : '0;

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wen_o   = wen_q;
  assign busy_o      = (state_q != S_IDLE);

  for (genvar r = 0; r < N_REQ; r++) begin : g_lane
    mem_rr_arbiter_lane u_lane (
      .req  (req_i[r]),
      .kill (kill_i[r]),
      .sel  (owner_q == OW'(r)),
      .fire (ack_fire),
      .elig (elig[r]),
      .ack  (ack_o[r])
    );
  end

  // Search starts one past the last winner and wraps mod N_REQ, so the modulo
  // is done on an int before narrowing (N_REQ need not be a power of two).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = OW'((int'(last_q) + i) % N_REQ);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timer_d   = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d   = S_BUSY;
          mem_req_d = 1'b1;
          addr_d    = addr_arr[win_idx];
          wdata_d   = wdata_arr[win_idx];
          wen_d     = wen_i[win_idx];
          owner_d   = win_idx;
          last_d    = win_idx;
        end
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end else if (kill_i[owner_q]) begin
          // Memory still owes us a response: keep the request up and drain.
          state_d = S_KILL;
          timer_d = '0;
        end
      end
      S_KILL: begin
        if (mem_ack_i || timer_hit) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      owner_q   <= '0;
      last_q    <= OW'(N_REQ - 1);
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TO = 240;
  localparam logic [AW-1:0] A [N] = '{32'h1000_0000, 32'h8000_0040, 32'h2000_0080};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_i = '0, kill_i = '0, wen_i = '0;
  logic [N*AW-1:0] addr_i = '0;
  logic [N*DW-1:0] wdata_i = '0;
  logic            mem_ack_i = 1'b0;
  logic [DW-1:0]   mem_rdata_i = '0;
  logic [N-1:0]    ack_o;
  logic [DW-1:0]   rdata_o, mem_wdata_o;
  logic            mem_req_o, mem_wen_o, busy_o, timeout_o;
  logic [AW-1:0]   mem_addr_o;

  mem_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .kill_i(kill_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wen_i(wen_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wen_o(mem_wen_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [N-1:0] ack_seen = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an outstanding transaction is 0=none, 1=live, 2=killed
  // (draining). kcnt counts drain cycles already spent.
  int            m_act = 0, m_own = 0, m_last = N - 1, m_kcnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_wen = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0]  e_ack;
    logic [DW-1:0] e_rd;
    logic          e_to;
    int            c, found;
    e_ack = '0;
    e_rd  = '0;
    e_to  = 1'b0;
    if (!rst && m_act == 1 && mem_ack_i && !bit_of(kill_i, m_own)) begin
      e_ack = N'(1) << m_own;
      e_rd  = mem_rdata_i;
    end
    if (!rst && m_act == 2 && !mem_ack_i && m_kcnt == TO - 1) e_to = 1'b1;
    if (chk_en) begin
      chk("busy", busy_o, m_act != 0);
      chk("mem_req", mem_req_o, m_act != 0);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("mem_wen", mem_wen_o, m_wen);
      chk("ack", ack_o, e_ack);
      chk("rdata", rdata_o, e_rd);
      chk("timeout", timeout_o, e_to);
      chk("ack_onehot", $onehot0(ack_o), 1);
    end
    ack_seen = ack_o;
    if (rst) begin
      m_act = 0; m_own = 0; m_last = N - 1; m_kcnt = 0;
      m_addr = '0; m_wdata = '0; m_wen = 1'b0;
    end else if (m_act == 0) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (found < 0 && bit_of(req_i & ~kill_i, c)) found = c;
      end
      if (found >= 0) begin
        m_act = 1; m_own = found; m_last = found;
        m_addr = addr_i[found*AW +: AW];
        m_wdata = wdata_i[found*DW +: DW];
        m_wen = bit_of(wen_i, found);
      end
    end else if (m_act == 1) begin
      if (mem_ack_i) m_act = 0;
      else if (bit_of(kill_i, m_own)) begin m_act = 2; m_kcnt = 0; end
    end else begin
      if (mem_ack_i || m_kcnt == TO - 1) m_act = 0;
      else m_kcnt++;
    end
  end

  // Owner r is killed one cycle into BUSY; memory stays silent except an
  // optional ack exactly in the timeout cycle.
  task automatic run_kill(input int r, input bit ack_end);
    cyc(); req_i = N'(1) << r; @(negedge clk);
    cyc(); kill_i = N'(1) << r; @(negedge clk);
    chk("kill_busy_req", mem_req_o, 1);
    cyc(); req_i = '0; kill_i = '0; @(negedge clk);
    for (int k = 1; k <= TO - 2; k++) begin
      cyc(); @(negedge clk);
      if (k == TO - 2) begin
        chk("kill_pre_to", timeout_o, 0);
        chk("kill_pre_req", mem_req_o, 1);
      end
    end
    cyc(); mem_ack_i = ack_end; @(negedge clk);
    chk("kill_to_pulse", timeout_o, !ack_end);
    chk("kill_to_ack", ack_o, 0);
    cyc(); mem_ack_i = 1'b0; @(negedge clk);
    chk("kill_end_busy", busy_o, 0);
    chk("kill_end_req", mem_req_o, 0);
    chk("kill_end_to", timeout_o, 0);
  endtask

  bit pend [N];
  bit mem_busy = 1'b0;
  int lat = -1;

  task automatic rand_cycles(input int n, input int maxlat, input int kdiv, input int rdiv);
    for (int t = 0; t < n; t++) begin
      cyc();
      for (int r = 0; r < N; r++) begin
        if (pend[r] && (bit_of(ack_seen, r) || bit_of(kill_i, r))) begin
          pend[r] = 1'b0; req_i[r] = 1'b0; kill_i[r] = 1'b0;
        end else if (!pend[r] && $urandom % 4 == 0) begin
          pend[r] = 1'b1; req_i[r] = 1'b1;
          addr_i[r*AW +: AW] = $urandom;
          wdata_i[r*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
          wen_i[r] = $urandom % 2 == 0;
        end else if (pend[r] && $urandom % kdiv == 0) begin
          kill_i[r] = 1'b1;
        end
      end
      rst = ($urandom % rdiv == 0);
      mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      if (!mem_req_o) begin
        mem_busy = 1'b0;
        mem_ack_i = ($urandom % 16 == 0);
      end else begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          lat = $urandom_range(0, maxlat);
        end
        mem_ack_i = (lat == 0);
        lat--;
      end
    end
  endtask

  initial begin : main
    int order [$];
    int cnt;
    for (int r = 0; r < N; r++) addr_i[r*AW +: AW] = A[r];
    cyc(); chk_en = 1'b1;
    cyc(); @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);

    // Grant/ack timing and r1 read data.
    cyc(); rst = 1'b0; req_i = 3'b011; @(negedge clk);
    chk("c0_req", mem_req_o, 0);
    cyc(); @(negedge clk);
    chk("c1_req", mem_req_o, 1);
    chk("c1_addr", mem_addr_o, A[0]);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); mem_ack_i = 1'b1; mem_rdata_i = 128'h1234; @(negedge clk);
    chk("c4_ack", ack_o, 3'b001);
    cyc(); mem_ack_i = 1'b0; req_i = 3'b010; @(negedge clk);
    chk("c5_req", mem_req_o, 0);
    chk("c5_busy", busy_o, 0);
    cyc(); @(negedge clk);
    chk("c6_addr", mem_addr_o, 32'h8000_0040);
    chk("c6_wen", mem_wen_o, 0);
    cyc(); mem_ack_i = 1'b1;
    mem_rdata_i = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001; @(negedge clk);
    chk("r1_ack", ack_o, 3'b010);
    chk("r1_rdata", rdata_o, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001);
    cyc(); mem_ack_i = 1'b0; req_i = '0; @(negedge clk);
    chk("c8_busy", busy_o, 0);

    // Kill then late ack (r2 write).
    cyc(); req_i = 3'b100; wen_i = 3'b100; wdata_i[2*DW +: DW] = 128'hCAFE_F00D; @(negedge clk);
    cyc(); @(negedge clk);
    chk("k_addr", mem_addr_o, A[2]);
    chk("k_wen", mem_wen_o, 1);
    chk("k_wdata", mem_wdata_o, 128'hCAFE_F00D);
    cyc(); kill_i = 3'b100; @(negedge clk);
    chk("k_ack0", ack_o, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(); kill_i = '0; req_i = '0; @(negedge clk);
      chk("k_hold_req", mem_req_o, 1);
      chk("k_hold_ack", ack_o, 0);
    end
    cyc(); mem_ack_i = 1'b1; @(negedge clk);
    chk("k_lateack", ack_o, 0);
    cyc(); mem_ack_i = 1'b0; @(negedge clk);
    chk("k_idle", busy_o, 0);

    // Kill arriving together with the ack (r0).
    cyc(); req_i = 3'b001; wen_i = '0; @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); kill_i = 3'b001; mem_ack_i = 1'b1; @(negedge clk);
    chk("ka_ack", ack_o, 0);
    chk("ka_rdata", rdata_o, 0);
    cyc(); kill_i = '0; mem_ack_i = 1'b0; req_i = '0; @(negedge clk);
    chk("ka_idle", busy_o, 0);

    run_kill(1, 1'b0);
    run_kill(2, 1'b1);

    // Reset during a BUSY write, then all requesters held.
    cyc(); req_i = 3'b100; wen_i = 3'b100; @(negedge clk);
    cyc(); @(negedge clk);
    chk("r6_wen", mem_wen_o, 1);
    cyc(); rst = 1'b1; mem_ack_i = 1'b1; @(negedge clk);
    chk("r6_noack", ack_o, 0);
    cyc(); rst = 1'b0; mem_ack_i = 1'b0; req_i = 3'b111; @(negedge clk);
    chk("r6_req", mem_req_o, 0);
    chk("r6_busy", busy_o, 0);

    cnt = -1;
    for (int k = 0; k < 30; k++) begin
      cyc(); mem_ack_i = (cnt == 1); mem_rdata_i = 128'(k); @(negedge clk);
      if (mem_ack_i) cnt = -1;
      else if (cnt >= 0) cnt++;
      else if (mem_req_o) begin
        for (int r = 0; r < N; r++) if (mem_addr_o == A[r]) order.push_back(r);
        cnt = 0;
      end
    end
    chk("rr_count", order.size() >= 5, 1);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", order[i], i % 3);

    cyc(); rst = 1'b1; req_i = '0; mem_ack_i = 1'b0; @(negedge clk);
    rand_cycles(3000, 5, 20, 400);
    rand_cycles(4000, 400, 8, 100000);
    cyc(); req_i = '0; kill_i = '0; mem_ack_i = 1'b0; rst = 1'b0; @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
